// File: rtl/apb2nmi_pkg.sv
// ---------------------------------------------------------------------------
// apb2nmi_pkg -- shared types and constants for the APB4 to native memory
// interface (NMI) bridge.
//
// Contents:
//   apb2nmi_state_t  bridge FSM state (IDLE, REQ, RESP)
//   APB2NMI_TMO_W    width of the optional request timeout counter
//   in_window()      address window decode shared by the bridge
// ---------------------------------------------------------------------------
package apb2nmi_pkg;

  localparam int APB2NMI_TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } apb2nmi_state_t;

  // True when base <= addr < base + size. The sum is formed on 33 bits so a
  // window that ends exactly at the top of the 4 GiB space does not wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] win_end;
    win_end = {1'b0, base} + {1'b0, size};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < win_end);
  endfunction

endpackage

// File: rtl/apb2nmi_if.sv
// ---------------------------------------------------------------------------
// apb2nmi_if -- bundle of the APB4 slave port and the NMI master port of the
// apb2nmi bridge. Signal names keep the bridge-side direction suffixes.
//
// Modports:
//   slave   bridge view: APB request inputs, APB response outputs,
//           NMI request outputs, NMI completion inputs
//   master  environment view (APB master + NMI target), directions mirrored
//
// APB4 : paddr_i[31:0] pprot_i[2:0] psel_i penable_i pwrite_i pwdata_i[31:0]
//        pstrb_i[3:0] -> pready_o prdata_o[31:0] pslverr_o
// NMI  : nmi_valid_o nmi_addr_o[31:0] nmi_wdata_o[31:0] nmi_wstrb_o[3:0]
//        <- nmi_ready_i nmi_rdata_i[31:0]
// ---------------------------------------------------------------------------
interface apb2nmi_if;

  logic [31:0] paddr_i;
  logic [2:0]  pprot_i;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;

  logic        nmi_valid_o;
  logic        nmi_ready_i;
  logic [31:0] nmi_addr_o;
  logic [31:0] nmi_wdata_o;
  logic [3:0]  nmi_wstrb_o;
  logic [31:0] nmi_rdata_i;

  modport slave (
    input  paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o,
    output nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o,
    input  nmi_ready_i, nmi_rdata_i
  );

  modport master (
    output paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o,
    input  nmi_valid_o, nmi_addr_o, nmi_wdata_o, nmi_wstrb_o,
    output nmi_ready_i, nmi_rdata_i
  );

endinterface

// File: rtl/apb2nmi_tmo.sv
// ---------------------------------------------------------------------------
// apb2nmi_tmo -- request timeout counter for apb2nmi. Only instantiated when
// the APB2NMI_TIMEOUT_EN macro is defined.
//
// Parameters:
//   LIMIT   number of enabled cycles after which expire fires (1..65535)
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset (counter -> 0)
//   clr     synchronous clear, wins over en
//   en      count this cycle
//   expire  high during the LIMIT-th enabled cycle since the last clear
// ---------------------------------------------------------------------------
module apb2nmi_tmo
  import apb2nmi_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [APB2NMI_TMO_W-1:0] LAST = APB2NMI_TMO_W'(LIMIT - 1);

  logic [APB2NMI_TMO_W-1:0] cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // The count equals the number of earlier enabled cycles, so comparing
  // against LIMIT-1 fires on the LIMIT-th cycle and the request is held for
  // exactly LIMIT cycles.
  assign expire = en && (cnt_reg == LAST);

endmodule

// File: rtl/apb2nmi.sv
// ---------------------------------------------------------------------------
// apb2nmi -- APB4 slave to native memory interface (NMI) bridge.
//
// An APB setup phase hitting [ADDR_BASE, ADDR_BASE+ADDR_SIZE) becomes one NMI
// request (valid held until ready); the APB access phase is stretched until
// the NMI completes. Addresses outside the window complete with zero wait
// states and PSLVERR. One transfer is outstanding at most.
//
// Optional feature: define APB2NMI_TIMEOUT_EN to bound each NMI request to
// TIMEOUT_CYC cycles; an expired request drops valid and returns PSLVERR.
// Without the macro a request waits indefinitely.
//
// Parameters:
//   ADDR_BASE    first byte address of the forwarded window
//   ADDR_SIZE    window size in bytes (power of two, non-zero)
//   TIMEOUT_CYC  request timeout in cycles, 1..65535 (macro builds only)
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   bus          apb2nmi_if.slave: APB4 slave port + NMI master port
// ---------------------------------------------------------------------------
module apb2nmi
  import apb2nmi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE   = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic      clk_i,
  input  logic      rst_i,
  apb2nmi_if.slave  bus
);

  apb2nmi_state_t state_reg, state_next;

  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        write_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic setup;
  logic in_win;
  logic tmo_expire;

  // pprot carries no meaning for this bridge
  wire unused_pprot = ^bus.pprot_i;

  assign setup  = bus.psel_i && !bus.penable_i;
  assign in_win = in_window(bus.paddr_i, ADDR_BASE, ADDR_SIZE);

`ifdef APB2NMI_TIMEOUT_EN
  logic tmo_clr;

  // Clear on the IDLE->REQ transition so the first REQ cycle counts as one.
  assign tmo_clr = (state_reg == IDLE) && setup && in_win;

  apb2nmi_tmo #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (tmo_clr),
    .en     (state_reg == REQ),
    .expire (tmo_expire)
  );
`else
  wire [APB2NMI_TMO_W-1:0] unused_tmo_cfg = TIMEOUT_CYC[APB2NMI_TMO_W-1:0];

  assign tmo_expire = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (setup) begin
          state_next = in_win ? REQ : RESP;
        end
      end
      REQ: begin
        // ready wins over a coincident timeout
        if (bus.nmi_ready_i || tmo_expire) begin
          state_next = RESP;
        end
      end
      // RESP lasts one cycle whether or not the master is still there to
      // take the response; an abandoned transfer is simply dropped.
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Transfer context
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      write_reg <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (setup) begin
            addr_reg  <= {bus.paddr_i[31:2], 2'b00};
            wdata_reg <= bus.pwdata_i;
            wstrb_reg <= bus.pwrite_i ? bus.pstrb_i : 4'h0;
            write_reg <= bus.pwrite_i;
            rdata_reg <= '0;
            err_reg   <= !in_win;
          end
        end
        REQ: begin
          if (bus.nmi_ready_i) begin
            rdata_reg <= write_reg ? 32'h0 : bus.nmi_rdata_i;
            err_reg   <= 1'b0;
          end else if (tmo_expire) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.nmi_valid_o = (state_reg == REQ);
  assign bus.nmi_addr_o  = addr_reg;
  assign bus.nmi_wdata_o = wdata_reg;
  assign bus.nmi_wstrb_o = wstrb_reg;

  // pready only while the master is still in its access phase; response
  // fields are forced to zero outside the pready cycle.
  assign bus.pready_o  = (state_reg == RESP) && bus.psel_i && bus.penable_i;
  assign bus.pslverr_o = bus.pready_o && err_reg;
  assign bus.prdata_o  = (bus.pready_o && !err_reg) ? rdata_reg : 32'h0;

endmodule

// File: tb/tb_apb2nmi.sv
// ---------------------------------------------------------------------------
// tb_apb2nmi -- self-checking bench for apb2nmi. Acts as APB master and NMI
// target; expected results come from a transaction-level model of the
// bridge (window decode, latency = ready delay + 1, error/data rules).
// Honours APB2NMI_TIMEOUT_EN for the timeout scenario.
// ---------------------------------------------------------------------------
module tb_apb2nmi;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h1000_0000;
  localparam int          TMO  = 8;
  localparam int          BUDGET = 400;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  apb2nmi_if bus ();

  apb2nmi #(
    .ADDR_BASE   (BASE),
    .ADDR_SIZE   (SIZE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"},  32'(bus.nmi_valid_o), 0);
    chk({tag, "_pready"}, 32'(bus.pready_o), 0);
    chk({tag, "_pslverr"}, 32'(bus.pslverr_o), 0);
    chk({tag, "_prdata"}, bus.prdata_o, 0);
    chk({tag, "_addr"},   bus.nmi_addr_o, 0);
    chk({tag, "_wdata"},  bus.nmi_wdata_o, 0);
    chk({tag, "_wstrb"},  32'(bus.nmi_wstrb_o), 0);
  endtask

  function automatic bit ref_in_win(input logic [31:0] a);
    longint unsigned al, lo, hi;
    al = longint'(a);
    lo = longint'(BASE);
    hi = lo + longint'(SIZE);
    return (al >= lo) && (al < hi);
  endfunction

  // Caller is at posedge+1. k = valid cycle on which ready is given
  // (1 = same cycle valid rises), 0 = never. Returns at posedge+1 of the
  // cycle after pready, so an immediate next call is back-to-back.
  task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                          input logic [3:0] st, input int k, input logic [31:0] rd);
    bit          inwin, tmo_hit, exp_err, done;
    int          exp_valid, exp_lat, n_valid, cyc;
    logic [31:0] exp_rdata;
    inwin = ref_in_win(addr);
`ifdef APB2NMI_TIMEOUT_EN
    tmo_hit = inwin && (k == 0 || k > TMO);
`else
    tmo_hit = 1'b0;
`endif
    exp_valid = !inwin ? 0 : (tmo_hit ? TMO : k);
    exp_lat   = exp_valid + 1;
    exp_err   = !inwin || tmo_hit;
    exp_rdata = (exp_err || wr) ? 32'h0 : rd;
    n_valid = 0;
    done    = 1'b0;

    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.paddr_i   = addr;
    bus.pwrite_i  = wr;
    bus.pwdata_i  = wd;
    bus.pstrb_i   = st;
    bus.pprot_i   = 3'($urandom);
    bus.nmi_ready_i = 1'b0;
    @(negedge clk_i);
    chk("setup_valid", 32'(bus.nmi_valid_o), 0);
    chk("setup_pready", 32'(bus.pready_o), 0);
    @(posedge clk_i); #1;
    bus.penable_i = 1'b1;
    cyc = 1;
    while (!done && cyc <= BUDGET) begin
      if (bus.nmi_valid_o) begin
        n_valid++;
        bus.nmi_ready_i = (n_valid == k);
        bus.nmi_rdata_i = bus.nmi_ready_i ? rd : $urandom;
        if (n_valid == 1 || bus.nmi_ready_i) begin
          chk("nmi_addr",  bus.nmi_addr_o, addr & ~32'h3);
          chk("nmi_wdata", bus.nmi_wdata_o, wd);
          chk("nmi_wstrb", 32'(bus.nmi_wstrb_o), wr ? 32'(st) : 32'h0);
        end
      end else begin
        // ready/rdata outside a request must be ignored
        bus.nmi_ready_i = 1'($urandom_range(0, 1));
        bus.nmi_rdata_i = $urandom;
      end
      @(negedge clk_i);
      if (bus.pready_o) begin
        done = 1'b1;
        chk("latency",   32'(cyc), 32'(exp_lat));
        chk("nvalid",    32'(n_valid), 32'(exp_valid));
        chk("pslverr",   32'(bus.pslverr_o), 32'(exp_err));
        chk("prdata",    bus.prdata_o, exp_rdata);
      end else begin
        chk("wait_prdata",  bus.prdata_o, 0);
        chk("wait_pslverr", 32'(bus.pslverr_o), 0);
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("pready_seen", 32'(done), 1);
    bus.psel_i      = 1'b0;
    bus.penable_i   = 1'b0;
    bus.nmi_ready_i = 1'b0;
    $display("xfer addr=%08h wr=%0d k=%0d inwin=%0d lat=%0d nvalid=%0d err=%0d",
             addr, wr, k, inwin, cyc - 1, n_valid, exp_err);
  endtask

  task automatic idle(input int n);
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    bus.paddr_i = '0; bus.pprot_i = '0; bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    bus.pwrite_i = 1'b0; bus.pwdata_i = '0; bus.pstrb_i = '0;
    bus.nmi_ready_i = 1'b0; bus.nmi_rdata_i = '0;

    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_outputs_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(2);

    // directed vectors
    apb_xfer(32'h0000_0104, 1'b0, 32'h0, 4'hF, 3, 32'hDEAD_BEEF);
    idle(1);
    apb_xfer(32'h0000_0010, 1'b1, 32'h1234_5678, 4'b0011, 1, 32'hA5A5_A5A5);
    idle(1);
    apb_xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0, 1, 32'hFFFF_FFFF);
    apb_xfer(32'h0FFF_FFFF, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D);
    apb_xfer(32'h1000_0000, 1'b1, 32'h1111_2222, 4'hF, 1, 32'h0);
    // back-to-back writes
    apb_xfer(32'h0000_0000, 1'b1, 32'hCAFE_0000, 4'hF, 2, 32'h0);
    apb_xfer(32'h0000_0004, 1'b1, 32'hCAFE_0004, 4'b1000, 1, 32'h0);
    idle(1);

    // request that is never answered
`ifdef APB2NMI_TIMEOUT_EN
    apb_xfer(32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 32'h1234_0000);
`else
    apb_xfer(32'h0000_0100, 1'b0, 32'h0, 4'h0, 120, 32'h1234_0000);
`endif
    idle(1);

    // reset pulse during REQ cycle 2, then a clean read
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.paddr_i = 32'h40; bus.pwrite_i = 1'b0;
    @(posedge clk_i); #1;
    bus.penable_i = 1'b1;
    chk("rst_pre_valid", 32'(bus.nmi_valid_o), 1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(1);
    apb_xfer(32'h0000_0020, 1'b0, 32'h0, 4'h0, 2, 32'h5566_7788);
    idle(1);

    // master abandons the transfer during REQ
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.paddr_i = 32'h8; bus.pwrite_i = 1'b1;
    bus.pwdata_i = 32'h7777_7777; bus.pstrb_i = 4'hF;
    @(posedge clk_i); #1;
    bus.penable_i = 1'b1;
    @(posedge clk_i); #1;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    chk("drop_valid_held", 32'(bus.nmi_valid_o), 1);
    bus.nmi_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.nmi_ready_i = 1'b0;
    @(negedge clk_i);
    chk("drop_valid_off", 32'(bus.nmi_valid_o), 0);
    chk("drop_no_pready", 32'(bus.pready_o), 0);
    @(posedge clk_i); #1;
    apb_xfer(32'h0000_0030, 1'b0, 32'h0, 4'h0, 1, 32'h3030_3030);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0FFF_FFFF);
      apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
               $urandom_range(1, 6), $urandom);
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/apb2nmi.md
APB2NMI -- requirements
Module: apb2nmi

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000, first byte address of the forwarded window.
REQ-002 Parameter ADDR_SIZE, default 32'h1000_0000, window size in bytes; power of two; non-zero.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles to wait for nmi_ready_i; range 1..65535.
REQ-004 Single clock, asynchronous active-high reset.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 paddr_i  input  32  APB4 address.
REQ-008 pprot_i  input  3  APB4 protection; ignored.
REQ-009 psel_i / penable_i / pwrite_i  input  1 each  APB4 select, enable and direction.
REQ-010 pwdata_i  input  32  APB4 write data.
REQ-011 pstrb_i  input  4  APB4 byte strobes.
REQ-012 pready_o  output  1  APB4 ready.
REQ-013 prdata_o  output  32  APB4 read data.
REQ-014 pslverr_o  output  1  APB4 error.
REQ-015 nmi_valid_o  output  1  native memory request valid.
REQ-016 nmi_ready_i  input  1  native memory request complete.
REQ-017 nmi_addr_o  output  32  word address, bits [1:0] forced 0.
REQ-018 nmi_wdata_o  output  32  write data.
REQ-019 nmi_wstrb_o  output  4  byte strobes; 4'h0 marks a read.
REQ-020 nmi_rdata_i  input  32  read data; sampled only when nmi_valid_o and nmi_ready_i are both high.

Function
REQ-021 FSM states: IDLE, REQ, RESP.
REQ-022 IDLE: on psel_i=1 and penable_i=0 (setup phase), latch paddr_i, pwdata_i and pwrite_i; latch pstrb_i for writes, 4'h0 for reads.
REQ-023 From IDLE: in-window address (ADDR_BASE <= paddr_i < ADDR_BASE+ADDR_SIZE) -> REQ; out-of-window -> RESP with err=1, no NMI request issued.
REQ-024 REQ: nmi_valid_o=1, all nmi_* outputs stable until nmi_ready_i=1.
REQ-025 REQ: on nmi_ready_i=1, capture nmi_rdata_i for reads (0 for writes), err=0 -> RESP; nmi_valid_o drops the next cycle.
REQ-026 RESP: pready_o=1 for exactly one cycle while psel_i=1 and penable_i=1; pslverr_o=err; prdata_o=captured data (0 when err=1) -> IDLE.
REQ-027 Latency: setup at cycle T, nmi_valid_o high from T+1, nmi_ready_i at T+k, pready_o at T+k+1; out-of-window pready_o at T+1 (zero wait states).
REQ-028 pready_o=0 in IDLE and REQ; prdata_o=0 and pslverr_o=0 whenever pready_o=0.
REQ-029 psel_i dropping during REQ: NMI request still completes (valid never withdrawn); RESP then goes straight to IDLE without asserting pready_o.
REQ-030 Setup phases arriving while not in IDLE are ignored; one outstanding transfer maximum.

Reset
REQ-031 rst_i=1 forces IDLE asynchronously; nmi_valid_o=0, pready_o=0, pslverr_o=0, prdata_o=0, nmi_addr_o=0, nmi_wdata_o=0, nmi_wstrb_o=0, timeout counter=0.
REQ-032 Reset during REQ abandons the request with no completion; the first transfer after reset release behaves as from IDLE.

Configuration
REQ-033 Macro APB2NMI_TIMEOUT_EN defined: a counter clears on REQ entry and increments each REQ cycle. When it reaches TIMEOUT_CYC with nmi_ready_i=0: nmi_valid_o drops, err=1, data=0, -> RESP.
REQ-034 Macro APB2NMI_TIMEOUT_EN undefined: no counter is instantiated and REQ waits indefinitely for nmi_ready_i.

Structure
REQ-035 Package apb2nmi_pkg holds the state enum apb2nmi_state_t and the counter width constant APB2NMI_TMO_W=16.
REQ-036 Sub-module apb2nmi_tmo holds the timeout counter (inputs clr, en; output expire); it is instantiated only under APB2NMI_TIMEOUT_EN.

Verification
REQ-037 Read: paddr 0x0000_0104, nmi_ready_i after 3 cycles with rdata 0xDEADBEEF -> nmi_addr_o=0x104, nmi_wstrb_o=0, prdata_o=0xDEADBEEF, pslverr_o=0, pready_o at T+4.
REQ-038 Write: paddr 0x10, pwdata 0x1234_5678, pstrb 4'b0011, ready same cycle as valid -> nmi_wstrb_o=4'b0011, nmi_wdata_o=0x1234_5678, pready_o at T+2.
REQ-039 Out-of-window: paddr 0x2000_0000 -> nmi_valid_o never asserted, pready_o=1 and pslverr_o=1 at T+1, prdata_o=0.
REQ-040 Timeout (macro on, TIMEOUT_CYC=8): nmi_ready_i held 0 -> nmi_valid_o drops after 8 cycles, pslverr_o=1 on the next cycle; with the macro off, valid stays high for 100+ cycles.
REQ-041 Reset pulse in REQ cycle 2, then a read to 0x20 -> all outputs 0 during reset, the second transfer completes normally.
REQ-042 Back-to-back writes to 0x0 and 0x4 with no idle cycle between them -> two NMI requests in order, two pready_o pulses.
